// File: rtl/vga_pkg.sv
// Shared definitions for the VGA test-pattern source: default 640x480@60 timing,
// RGB565 colour constants and pattern_sel encodings.
package vga_pkg;

    localparam int H_SYNC_DEF   = 96;
    localparam int H_BACK_DEF   = 48;
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FRONT_DEF  = 16;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BACK_DEF   = 33;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FRONT_DEF  = 10;

    // Counter widths sized so x/y fall straight out of the counter offsets.
    localparam int H_CNT_W = 11;
    localparam int V_CNT_W = 10;

    localparam logic [15:0] WHITE   = 16'hFFFF;
    localparam logic [15:0] YELLOW  = 16'hFFE0;
    localparam logic [15:0] CYAN    = 16'h07FF;
    localparam logic [15:0] GREEN   = 16'h07E0;
    localparam logic [15:0] MAGENTA = 16'hF81F;
    localparam logic [15:0] RED     = 16'hF800;
    localparam logic [15:0] BLUE    = 16'h001F;
    localparam logic [15:0] BLACK   = 16'h0000;

    typedef enum logic [1:0] {
        PAT_BARS    = 2'd0,
        PAT_GRAY    = 2'd1,
        PAT_CHECKER = 2'd2,
        PAT_BORDER  = 2'd3
    } pattern_e;

    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = WHITE;
            3'd1:    c = YELLOW;
            3'd2:    c = CYAN;
            3'd3:    c = GREEN;
            3'd4:    c = MAGENTA;
            3'd5:    c = RED;
            3'd6:    c = BLUE;
            default: c = BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_timing_cnt.sv
// Horizontal/vertical raster counters with combinational region decode and
// active-area x/y coordinates; the top registers everything it produces.
module vga_timing_cnt
    import vga_pkg::*;
#(
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BACK   = H_BACK_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FRONT  = H_FRONT_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BACK   = V_BACK_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FRONT  = V_FRONT_DEF
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        en,
    output logic        hs_act,
    output logic        vs_act,
    output logic        active,
    output logic        frame_first,
    output logic [10:0] x,
    output logic [9:0]  y
);

    localparam logic [H_CNT_W-1:0] H_LAST   = H_CNT_W'(H_SYNC + H_BACK + H_ACTIVE + H_FRONT - 1);
    localparam logic [V_CNT_W-1:0] V_LAST   = V_CNT_W'(V_SYNC + V_BACK + V_ACTIVE + V_FRONT - 1);
    localparam logic [H_CNT_W-1:0] H_SYNC_C = H_CNT_W'(H_SYNC);
    localparam logic [V_CNT_W-1:0] V_SYNC_C = V_CNT_W'(V_SYNC);
    localparam logic [H_CNT_W-1:0] H_ACT_LO = H_CNT_W'(H_SYNC + H_BACK);
    localparam logic [H_CNT_W-1:0] H_ACT_HI = H_CNT_W'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [V_CNT_W-1:0] V_ACT_LO = V_CNT_W'(V_SYNC + V_BACK);
    localparam logic [V_CNT_W-1:0] V_ACT_HI = V_CNT_W'(V_SYNC + V_BACK + V_ACTIVE);

    logic [H_CNT_W-1:0] h_cnt;
    logic [V_CNT_W-1:0] v_cnt;
    logic [H_CNT_W-1:0] h_off;
    logic [V_CNT_W-1:0] v_off;
    logic               h_act;
    logic               v_act;

    // Dropping en aborts the frame outright so a restart always begins at h=0, v=0.
    always_ff @(posedge pclk) begin
        if (!rst_n || !en) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign hs_act      = (h_cnt < H_SYNC_C);
    assign vs_act      = (v_cnt < V_SYNC_C);
    assign h_act       = (h_cnt >= H_ACT_LO) && (h_cnt < H_ACT_HI);
    assign v_act       = (v_cnt >= V_ACT_LO) && (v_cnt < V_ACT_HI);
    assign active      = h_act && v_act;
    assign frame_first = (h_cnt == '0) && (v_cnt == '0);
    assign h_off       = h_cnt - H_ACT_LO;
    assign v_off       = v_cnt - V_ACT_LO;
    assign x           = active ? h_off : '0;
    assign y           = active ? v_off : '0;

endmodule

// File: rtl/vga_pattern_tx.sv
// VGA timing and RGB565 test-pattern source; pattern_sel is sampled once per
// frame and all outputs are registered together with no relative skew.
module vga_pattern_tx
    import vga_pkg::*;
#(
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BACK   = H_BACK_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FRONT  = H_FRONT_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BACK   = V_BACK_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FRONT  = V_FRONT_DEF,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [1:0]  pattern_sel,
    output logic        de_flag,
    output logic [15:0] data_rgb,
    output logic        hsync,
    output logic        vsync,
    output logic [10:0] pix_x,
    output logic [9:0]  pix_y,
    output logic        frame_start
);

    localparam logic [10:0] BAR_W  = 11'(H_ACTIVE / 8);
    localparam logic [10:0] X_LAST = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  Y_LAST = 10'(V_ACTIVE - 1);

    logic        hs_act;
    logic        vs_act;
    logic        active;
    logic        frame_first;
    logic [10:0] x;
    logic [9:0]  y;
    pattern_e    pat_q;
    logic [15:0] pix_rgb;

    vga_timing_cnt #(
        .H_SYNC   (H_SYNC),
        .H_BACK   (H_BACK),
        .H_ACTIVE (H_ACTIVE),
        .H_FRONT  (H_FRONT),
        .V_SYNC   (V_SYNC),
        .V_BACK   (V_BACK),
        .V_ACTIVE (V_ACTIVE),
        .V_FRONT  (V_FRONT)
    ) u_cnt (
        .pclk        (pclk),
        .rst_n       (rst_n),
        .en          (en),
        .hs_act      (hs_act),
        .vs_act      (vs_act),
        .active      (active),
        .frame_first (frame_first),
        .x           (x),
        .y           (y)
    );

    // Sampling only at the raster origin keeps a frame visually uniform.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            pat_q <= PAT_BARS;
        end else if (frame_first) begin
            pat_q <= pattern_e'(pattern_sel);
        end
    end

    always_comb begin
        pix_rgb = BLACK;
        unique case (pat_q)
            PAT_BARS:    pix_rgb = bar_colour(3'(x / BAR_W));
            PAT_GRAY:    pix_rgb = {x[7:3], x[7:2], x[7:3]};
            PAT_CHECKER: pix_rgb = (x[5] ^ y[5]) ? WHITE : BLACK;
            PAT_BORDER:  pix_rgb = ((x == '0) || (x == X_LAST) || (y == '0) || (y == Y_LAST))
                                   ? WHITE : BLACK;
        endcase
        if (!active) begin
            pix_rgb = BLACK;
        end
    end

    always_ff @(posedge pclk) begin
        if (!rst_n || !en) begin
            de_flag     <= 1'b0;
            data_rgb    <= BLACK;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
        end else begin
            de_flag     <= active;
            data_rgb    <= pix_rgb;
            hsync       <= hs_act ? SYNC_POL : ~SYNC_POL;
            vsync       <= vs_act ? SYNC_POL : ~SYNC_POL;
            pix_x       <= x;
            pix_y       <= y;
            frame_start <= frame_first;
        end
    end

endmodule

// File: tb/tb_vga_pattern_tx.sv
// Directed bench: a small-timing instance checked cycle by cycle, plus three
// default-timing instances (one per pattern) checked at hand-picked pixels.
module tb_vga_pattern_tx;

    logic        pclk;
    logic        rst_s, en_s;
    logic [1:0]  sel_s;
    logic        de_s, hs_s, vs_s, fs_s;
    logic [15:0] data_s;
    logic [10:0] px_s;
    logic [9:0]  py_s;
    logic [40:0] s_vec;

    logic        rst_d, en_d;
    logic [1:0]  sel_d   [3];
    logic        de_d    [3];
    logic        hs_d    [3];
    logic        vs_d    [3];
    logic        fs_d    [3];
    logic [15:0] data_d  [3];
    logic [10:0] px_d    [3];
    logic [9:0]  py_d    [3];

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [40:0] RST_VEC = {1'b1, 1'b1, 39'd0};
    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    vga_pattern_tx #(
        .H_SYNC(4), .H_BACK(2), .H_ACTIVE(8), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_ACTIVE(4), .V_FRONT(1),
        .SYNC_POL(1'b0)
    ) dut_s (
        .pclk        (pclk),
        .rst_n       (rst_s),
        .en          (en_s),
        .pattern_sel (sel_s),
        .de_flag     (de_s),
        .data_rgb    (data_s),
        .hsync       (hs_s),
        .vsync       (vs_s),
        .pix_x       (px_s),
        .pix_y       (py_s),
        .frame_start (fs_s)
    );

    assign s_vec = {hs_s, vs_s, de_s, fs_s, px_s, py_s, data_s};

    for (genvar i = 0; i < 3; i++) begin : g_def
        vga_pattern_tx dut_d (
            .pclk        (pclk),
            .rst_n       (rst_d),
            .en          (en_d),
            .pattern_sel (sel_d[i]),
            .de_flag     (de_d[i]),
            .data_rgb    (data_d[i]),
            .hsync       (hs_d[i]),
            .vsync       (vs_d[i]),
            .pix_x       (px_d[i]),
            .pix_y       (py_d[i]),
            .frame_start (fs_d[i])
        );
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Expected small-timing output for the k-th cycle of a frame sequence.
    function automatic logic [40:0] exp_s(input int k, input int pat);
        int h, v, x, y;
        logic hs, vs, act, fs;
        logic [15:0] d;
        h   = k % 16;
        v   = (k / 16) % 7;
        hs  = (h >= 4);
        vs  = (v >= 1);
        act = (h >= 6) && (h < 14) && (v >= 2) && (v < 6);
        fs  = (h == 0) && (v == 0);
        x   = act ? h - 6 : 0;
        y   = act ? v - 2 : 0;
        d   = 16'h0000;
        if (act) begin
            if (pat == 0)
                d = bars[x];
            else if (x == 0 || x == 7 || y == 0 || y == 3)
                d = 16'hFFFF;
        end
        return {hs, vs, act, fs, 11'(x), 10'(y), d};
    endfunction

    task automatic run_small();
        int fs_cnt = 0;
        int de_cnt = 0;
        int hs_low = 0;
        rst_s = 1'b1;
        en_s  = 1'b1;
        sel_s = 2'd0;
        for (int k = 0; k <= 488; k++) begin
            tick();
            chk("small_seq", 64'(s_vec), 64'(exp_s(k, (k >= 336) ? 3 : 0)));
            if (k < 224 && fs_s) fs_cnt++;
            if (k < 112 && de_s) de_cnt++;
            if (k < 16 && !hs_s) hs_low++;
            if (k == 230) sel_s = 2'd3;
        end
        chk("small_fs_per_2frames", 64'(fs_cnt), 64'd2);
        chk("small_de_per_frame", 64'(de_cnt), 64'd32);
        chk("small_hsync_low", 64'(hs_low), 64'd4);

        en_s = 1'b0;
        tick();
        chk("en_drop", 64'(s_vec), 64'(RST_VEC));
        tick();
        chk("en_hold", 64'(s_vec), 64'(RST_VEC));
        en_s = 1'b1;
        tick();
        chk("en_rise", 64'(s_vec), 64'(exp_s(0, 3)));
        for (int j = 1; j <= 20; j++) begin
            tick();
            chk("en_restart", 64'(s_vec), 64'(exp_s(j, 3)));
        end

        rst_s = 1'b0;
        tick();
        chk("rst_pulse", 64'(s_vec), 64'(RST_VEC));
        rst_s = 1'b1;
        for (int j = 0; j < 112; j++) begin
            tick();
            chk("rst_restart", 64'(s_vec), 64'(exp_s(j, 3)));
        end
    endtask

    task automatic run_default();
        int first_de = -1;
        logic [15:0] first_data = 16'h0;
        int de_line = 0;
        int v;
        localparam int A  = 35 * 800 + 144;
        localparam int A2 = 67 * 800 + 144;
        rst_d = 1'b1;
        en_d  = 1'b1;
        for (int k = 0; k < 53800; k++) begin
            tick();
            v = k / 800;
            if (de_d[0] && first_de < 0) begin
                first_de   = k;
                first_data = data_d[0];
            end
            if (v == 35 && de_d[0]) de_line++;
            if (k == 0)      chk("def_fs_first", 64'(fs_d[0]), 64'd1);
            if (k == 1)      chk("def_fs_second", 64'(fs_d[0]), 64'd0);
            if (k == 95)     chk("def_hsync_end", 64'(hs_d[0]), 64'd0);
            if (k == 96)     chk("def_hsync_off", 64'(hs_d[0]), 64'd1);
            if (k == 805)    chk("def_vsync_l1", 64'(vs_d[0]), 64'd0);
            if (k == 1600)   chk("def_vsync_off", 64'(vs_d[0]), 64'd1);
            if (k == A + 80) begin
                chk("bars_x80_x", 64'(px_d[0]), 64'd80);
                chk("bars_x80_rgb", 64'(data_d[0]), 64'hFFE0);
            end
            if (k == A + 639) begin
                chk("bars_x639_x", 64'(px_d[0]), 64'd639);
                chk("bars_x639_rgb", 64'(data_d[0]), 64'h0000);
                chk("bars_x639_de", 64'(de_d[0]), 64'd1);
            end
            if (k == A + 640) begin
                chk("bars_x640_de", 64'(de_d[0]), 64'd0);
                chk("bars_x640_x", 64'(px_d[0]), 64'd0);
            end
            if (k == A + 800) chk("bars_y1", 64'({de_d[0], px_d[0], py_d[0]}), 64'({1'b1, 11'd0, 10'd1}));
            if (k == A + 200) chk("gray_x200", 64'(data_d[1]), 64'hCE59);
            if (k == A)       chk("chk_x0_y0", 64'(data_d[2]), 64'h0000);
            if (k == A + 32)  chk("chk_x32_y0", 64'(data_d[2]), 64'hFFFF);
            if (k == A2)      chk("chk_x0_y32", 64'(data_d[2]), 64'hFFFF);
            if (k == A2 + 32) begin
                chk("chk_x32_y32", 64'(data_d[2]), 64'h0000);
                chk("chk_y32_pixy", 64'(py_d[2]), 64'd32);
            end
        end
        chk("def_first_de", 64'(first_de), 64'(A));
        chk("def_first_rgb", 64'(first_data), 64'hFFFF);
        chk("def_de_per_line", 64'(de_line), 64'd640);
    endtask

    initial begin
        rst_s    = 1'b0;
        en_s     = 1'b0;
        sel_s    = 2'd0;
        rst_d    = 1'b0;
        en_d     = 1'b0;
        sel_d[0] = 2'd0;
        sel_d[1] = 2'd1;
        sel_d[2] = 2'd2;
        repeat (3) tick();
        chk("reset_small", 64'(s_vec), 64'(RST_VEC));
        chk("reset_def", 64'({hs_d[0], vs_d[0], de_d[0], fs_d[0], px_d[0], py_d[0], data_d[0]}),
            64'(RST_VEC));
        fork
            run_small();
            run_default();
        join
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
